gmii_rx_framer: RTL and testbench

- Consumes the GMII receive byte stream (gmii_rx_clk, gmii_rx_dv, gmii_rxd) produced by the RGMII-to-GMII conversion stage.
- Detects and strips the preamble and SFD, and removes the 4-byte FCS.
- Emits frame bytes (destination MAC through last payload byte) with sop/eop framing.
- Checks CRC32 and length, and reports per-frame status plus good/bad frame counters to the downstream MAC/UDP logic.

---
 rtl/eth_pkg.sv | 32 +++
 rtl/crc32_d8.sv | 34 +++
 rtl/gmii_rx_framer.sv | 180 ++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Brief    : Shared Ethernet receive constants, FSM state type and helpers.
// Revision : 1.0
// ============================================================================
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] i_v);
        logic [31:0] w_r;
        for (int i = 0; i < 32; i++) begin
            w_r[i] = i_v[31-i];
        end
        return w_r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module   : crc32_d8
// Brief    : Combinational next-state of the reflected CRC32 for one byte.
// Revision : 1.0
// ============================================================================
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    // LSB-first shifting uses the bit-reversed polynomial.
    localparam logic [31:0] c_poly_refl = reflect32(CRC32_POLY);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ i_data[i]) begin
                w_crc = (w_crc >> 1) ^ c_poly_refl;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign o_crc = w_crc;

endmodule
`default_nettype wire

// File: rtl/gmii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : gmii_rx_framer
// Brief    : GMII receive framer: strips preamble/SFD and FCS, checks CRC32
//            and length, emits sop/eop framed bytes and good/bad counters.
// Revision : 1.0
// ============================================================================
module gmii_rx_framer
    import eth_pkg::*;
#(
    parameter int MIN_PRE = 1,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_crc_ok,
    output logic        rx_len_err,
    output logic [15:0] rx_frame_len,
    output logic [31:0] rx_good_cnt,
    output logic [31:0] rx_bad_cnt
);

    localparam logic [2:0]  c_min_pre = 3'(MIN_PRE);
    localparam logic [15:0] c_min_len = 16'(MIN_LEN);
    localparam logic [15:0] c_max_len = 16'(MAX_LEN);
    localparam int          c_depth   = 5;

    rx_state_t   r_state;
    logic [2:0]  r_pre_cnt;
    logic [7:0]  r_sr [0:c_depth-1];
    logic [31:0] r_crc;
    logic [15:0] r_byte_cnt;

    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_sop;
    logic        r_rx_eop;
    logic        r_rx_crc_ok;
    logic        r_rx_len_err;
    logic [15:0] r_rx_frame_len;
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;

    logic [31:0] w_crc_next;
    logic        w_crc_ok;
    logic        w_len_err;

    crc32_d8 u_crc32_d8 (
        .i_crc  (r_crc),
        .i_data (gmii_rxd),
        .o_crc  (w_crc_next)
    );

    assign w_crc_ok  = (r_crc == CRC32_RESIDUE);
    assign w_len_err = (r_byte_cnt < c_min_len) || (r_byte_cnt > c_max_len);

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pre_cnt      <= 3'd0;
            r_crc          <= CRC32_INIT;
            r_byte_cnt     <= 16'd0;
            for (int i = 0; i < c_depth; i++) begin
                r_sr[i] <= 8'd0;
            end
            r_rx_data      <= 8'd0;
            r_rx_valid     <= 1'b0;
            r_rx_sop       <= 1'b0;
            r_rx_eop       <= 1'b0;
            r_rx_crc_ok    <= 1'b0;
            r_rx_len_err   <= 1'b0;
            r_rx_frame_len <= 16'd0;
            r_good_cnt     <= 32'd0;
            r_bad_cnt      <= 32'd0;
        end else begin
            r_rx_data      <= 8'd0;
            r_rx_valid     <= 1'b0;
            r_rx_sop       <= 1'b0;
            r_rx_eop       <= 1'b0;
            r_rx_crc_ok    <= 1'b0;
            r_rx_len_err   <= 1'b0;
            r_rx_frame_len <= 16'd0;

            case (r_state)
                ST_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == PREAMBLE_BYTE) begin
                            r_state   <= ST_PREAMBLE;
                            r_pre_cnt <= 3'd1;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        r_state <= ST_IDLE;
                    end else if (gmii_rxd == PREAMBLE_BYTE) begin
                        if (r_pre_cnt != 3'd7) begin
                            r_pre_cnt <= r_pre_cnt + 3'd1;
                        end
                    end else if ((gmii_rxd == SFD_BYTE) && (r_pre_cnt >= c_min_pre)) begin
                        r_state    <= ST_DATA;
                        r_crc      <= CRC32_INIT;
                        r_byte_cnt <= 16'd0;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end

                ST_DATA: begin
                    if (gmii_rx_dv) begin
                        for (int i = c_depth - 1; i > 0; i--) begin
                            r_sr[i] <= r_sr[i-1];
                        end
                        r_sr[0] <= gmii_rxd;
                        r_crc   <= w_crc_next;
                        if (r_byte_cnt != 16'hFFFF) begin
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                        end
                        // A full delay line means its oldest byte cannot be FCS.
                        if (r_byte_cnt >= 16'(c_depth)) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_sr[c_depth-1];
                            r_rx_sop   <= (r_byte_cnt == 16'(c_depth));
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        // Frames that never emitted a sop end silently but still count as bad.
                        if (r_byte_cnt > 16'(c_depth)) begin
                            r_rx_valid     <= 1'b1;
                            r_rx_data      <= r_sr[c_depth-1];
                            r_rx_eop       <= 1'b1;
                            r_rx_crc_ok    <= w_crc_ok;
                            r_rx_len_err   <= w_len_err;
                            r_rx_frame_len <= r_byte_cnt;
                            if (w_crc_ok && !w_len_err) begin
                                r_good_cnt <= r_good_cnt + 32'd1;
                            end else begin
                                r_bad_cnt <= r_bad_cnt + 32'd1;
                            end
                        end else begin
                            r_bad_cnt <= r_bad_cnt + 32'd1;
                        end
                    end
                end

                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_sop       = r_rx_sop;
    assign rx_eop       = r_rx_eop;
    assign rx_crc_ok    = r_rx_crc_ok;
    assign rx_len_err   = r_rx_len_err;
    assign rx_frame_len = r_rx_frame_len;
    assign rx_good_cnt  = r_good_cnt;
    assign rx_bad_cnt   = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmii_rx_framer
// Brief    : Self-checking bench for gmii_rx_framer against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_gmii_rx_framer;

    localparam int MIN_PRE = 1;
    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic        crc_ok;
        logic        len_err;
        logic [15:0] len;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv  = 1'b0;
    logic [7:0]  rxd = 8'd0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, rx_crc_ok, rx_len_err;
    logic [15:0] rx_frame_len;
    logic [31:0] rx_good_cnt, rx_bad_cnt;

    beat_t       got_q[$];
    beat_t       exp_q[$];
    int          got_cyc[$];
    beat_t       mon_b;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          drive_cyc = 0;
    logic [31:0] exp_good = 32'd0;
    logic [31:0] exp_bad  = 32'd0;

    always #4 clk = ~clk;

    gmii_rx_framer #(.MIN_PRE(MIN_PRE), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .gmii_rx_clk  (clk),
        .rst          (rst),
        .gmii_rx_dv   (dv),
        .gmii_rxd     (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sop       (rx_sop),
        .rx_eop       (rx_eop),
        .rx_crc_ok    (rx_crc_ok),
        .rx_len_err   (rx_len_err),
        .rx_frame_len (rx_frame_len),
        .rx_good_cnt  (rx_good_cnt),
        .rx_bad_cnt   (rx_bad_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Status fields only carry meaning on eop, so they are masked elsewhere.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            mon_b.d       = rx_data;
            mon_b.sop     = rx_sop;
            mon_b.eop     = rx_eop;
            mon_b.crc_ok  = rx_eop ? rx_crc_ok : 1'b0;
            mon_b.len_err = rx_eop ? rx_len_err : 1'b0;
            mon_b.len     = rx_eop ? rx_frame_len : 16'd0;
            got_q.push_back(mon_b);
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] crc32(input bq_t b, input int s, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, b[s+i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t mk_frame(input int npre, input int nbody);
        bq_t q;
        logic [31:0] fcs;
        for (int i = 0; i < npre; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < nbody; i++) q.push_back(8'($urandom));
        fcs = crc32(q, npre + 1, nbody);
        for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
        return q;
    endfunction

    // Frame-level reference: parse one dv burst and predict beats and counters.
    function automatic void model(input bq_t b);
        int k = 0;
        int n;
        logic [31:0] fcs;
        logic ok, lerr;
        beat_t bt;
        while (k < b.size() && b[k] == 8'h55) k++;
        if (k == 0 || k >= b.size() || b[k] != 8'hD5 || k < MIN_PRE) return;
        n = b.size() - k - 1;
        if (n <= 5) begin
            exp_bad++;
            return;
        end
        fcs  = {b[k+n], b[k+n-1], b[k+n-2], b[k+n-3]};
        ok   = (crc32(b, k + 1, n - 4) == fcs);
        lerr = (n < MIN_LEN) || (n > MAX_LEN);
        for (int j = 0; j < n - 4; j++) begin
            bt.d       = b[k+1+j];
            bt.sop     = (j == 0);
            bt.eop     = (j == n - 5);
            bt.crc_ok  = bt.eop & ok;
            bt.len_err = bt.eop & lerr;
            bt.len     = bt.eop ? 16'(n) : 16'd0;
            exp_q.push_back(bt);
        end
        if (ok && !lerr) exp_good++;
        else exp_bad++;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dv  = 1'b0;
            rxd = 8'd0;
        end
    endtask

    task automatic send_burst(input bq_t b, input int gap, input int rst_at = -1);
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b1;
                dv  = 1'b0;
                rxd = 8'd0;
                @(negedge clk);
                return;
            end
            dv  = 1'b1;
            rxd = b[i];
            if (i == 0) drive_cyc = cyc;
        end
        idle(gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dv  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_good = 32'd0;
        exp_bad  = 32'd0;
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_valid, rx_sop, rx_eop, rx_crc_ok, rx_len_err, rx_data, rx_frame_len} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rx_valid, rx_sop, rx_eop, rx_crc_ok, rx_len_err, rx_data, rx_frame_len});
        end
        checks++;
        if ({rx_good_cnt, rx_bad_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters: got good=%0d bad=%0d required 0", rx_good_cnt, rx_bad_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        bq_t f;
        do_reset();
        f = mk_frame(7, 60);
        model(f);
        send_burst(f, 8);
        checks++;
        if (got_q.size() != 60) begin
            errors++;
            $display("FAIL good_beats: got %0d required 60", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL good_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() == 60) begin
            checks++;
            if (!got_q[59].eop || got_q[59].len !== 16'd64 || !got_q[59].crc_ok || got_q[59].len_err) begin
                errors++;
                $display("FAIL good_status: got %h required eop crc_ok len=64", got_q[59]);
            end
            checks++;
            if (got_cyc[0] != drive_cyc + 14) begin
                errors++;
                $display("FAIL good_latency: got cycle %0d required %0d", got_cyc[0], drive_cyc + 14);
            end
        end
        checks++;
        if (rx_good_cnt !== 32'd1 || rx_bad_cnt !== 32'd0) begin
            errors++;
            $display("FAIL good_counters: got good=%0d bad=%0d required 1/0", rx_good_cnt, rx_bad_cnt);
        end
    endtask

    task automatic test_bad_crc();
        bq_t f;
        do_reset();
        f = mk_frame(7, 60);
        f[8+10] = f[8+10] ^ 8'h04;
        model(f);
        send_burst(f, 8);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL badcrc_beats: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL badcrc_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_good_cnt !== 32'd0 || rx_bad_cnt !== 32'd1) begin
            errors++;
            $display("FAIL badcrc_counters: got good=%0d bad=%0d required 0/1", rx_good_cnt, rx_bad_cnt);
        end
    endtask

    task automatic test_short_frame();
        bq_t f;
        do_reset();
        f = mk_frame(7, 36);
        model(f);
        send_burst(f, 8);
        checks++;
        if (got_q.size() != 36) begin
            errors++;
            $display("FAIL short_beats: got %0d required 36", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL short_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_good_cnt !== 32'd0 || rx_bad_cnt !== 32'd1) begin
            errors++;
            $display("FAIL short_counters: got good=%0d bad=%0d required 0/1", rx_good_cnt, rx_bad_cnt);
        end
    endtask

    task automatic test_bad_preamble();
        bq_t f;
        do_reset();
        f = '{8'h55, 8'h55, 8'h5D};
        for (int i = 0; i < 20; i++) f.push_back(8'($urandom));
        model(f);
        send_burst(f, 4);
        checks++;
        if (got_q.size() != 0 || rx_good_cnt !== 32'd0 || rx_bad_cnt !== 32'd0) begin
            errors++;
            $display("FAIL badpre_quiet: got beats=%0d good=%0d bad=%0d required 0/0/0",
                     got_q.size(), rx_good_cnt, rx_bad_cnt);
        end
        f = mk_frame(7, 60);
        model(f);
        send_burst(f, 8);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL badpre_next_beats: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL badpre_next_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_good_cnt !== 32'd1 || rx_bad_cnt !== 32'd0) begin
            errors++;
            $display("FAIL badpre_counters: got good=%0d bad=%0d required 1/0", rx_good_cnt, rx_bad_cnt);
        end
    endtask

    task automatic test_runt();
        bq_t f;
        do_reset();
        f = '{8'h55, 8'hD5, 8'h01, 8'h02, 8'h03};
        model(f);
        send_burst(f, 6);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL runt_beats: got %0d required 0", got_q.size());
        end
        checks++;
        if (rx_good_cnt !== 32'd0 || rx_bad_cnt !== 32'd1 || exp_bad !== 32'd1) begin
            errors++;
            $display("FAIL runt_counters: got good=%0d bad=%0d required 0/1", rx_good_cnt, rx_bad_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bq_t f;
        do_reset();
        f = mk_frame(7, 60);
        model(f);
        exp_good = 32'd0;
        exp_bad  = 32'd0;
        while (exp_q.size() > 25) void'(exp_q.pop_back());
        send_burst(f, 0, 8 + 30);
        checks++;
        if ({rx_valid, rx_sop, rx_eop, rx_crc_ok, rx_len_err, rx_data, rx_frame_len} !== 29'd0
            || rx_good_cnt !== 32'd0 || rx_bad_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got valid=%b eop=%b data=%h good=%0d bad=%0d required all 0",
                     rx_valid, rx_eop, rx_data, rx_good_cnt, rx_bad_cnt);
        end
        rst = 1'b0;
        idle(6);
        checks++;
        if (got_q.size() != 25) begin
            errors++;
            $display("FAIL rstmid_beats: got %0d required 25", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
        f = mk_frame(7, 60);
        model(f);
        send_burst(f, 8);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_next_beats: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_next_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_good_cnt !== exp_good || rx_bad_cnt !== exp_bad) begin
            errors++;
            $display("FAIL rstmid_counters: got good=%0d bad=%0d required %0d/%0d",
                     rx_good_cnt, rx_bad_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic test_boundary();
        int lens[6] = '{5, 6, 63, 64, 1518, 1519};
        bq_t f;
        do_reset();
        foreach (lens[i]) begin
            f = mk_frame(1 + (i % 7), lens[i] - 4);
            model(f);
            send_burst(f, 1);
        end
        idle(6);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL boundary_beats: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (exp_q[i].sop || exp_q[i].eop || i < 8) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL boundary_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rx_good_cnt !== exp_good || rx_bad_cnt !== exp_bad) begin
            errors++;
            $display("FAIL boundary_counters: got good=%0d bad=%0d required %0d/%0d",
                     rx_good_cnt, rx_bad_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic test_random();
        bq_t f;
        int kind;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 9);
            f.delete();
            if (kind == 0) begin
                repeat ($urandom_range(1, 12)) f.push_back(8'($urandom));
            end else begin
                f = mk_frame($urandom_range(0, 9), $urandom_range(1, 110));
                if (kind <= 3) f[f.size() - 1 - $urandom_range(0, 4)] ^= 8'(1 << $urandom_range(0, 7));
            end
            model(f);
            send_burst(f, $urandom_range(1, 3));
        end
        idle(6);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_beats: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rx_good_cnt !== exp_good || rx_bad_cnt !== exp_bad) begin
            errors++;
            $display("FAIL random_counters: got good=%0d bad=%0d required %0d/%0d",
                     rx_good_cnt, rx_bad_cnt, exp_good, exp_bad);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_short_frame();
        test_bad_preamble();
        test_runt();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
